div_unit: RTL

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. Accepts operands and a start request from EX, iterates restoring division one quotient bit per cycle, and returns a 64-bit {remainder, quotient} result with a ready flag. EX writes the result to HI and LO. It sits beside EX in the top level, clocked with the pipeline. EX holds the pipeline stalled until ready is seen.

---
 rtl/div_if.sv | 22 ++
 rtl/div_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// EX drives operands and control (master); the divider returns the
// {remainder, quotient} result and its ready flag (slave).
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Operands are converted to magnitudes on acceptance, 32 restoring steps
// run on a 65-bit working register, and signs are reapplied when the
// result is presented. result_o is {remainder, quotient}.
module div_unit (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_BY_ZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;     // [64:33] remainder, [31:0] quotient after 32 steps
    logic [31:0] r_divisor;
    logic        r_neg1;     // signed mode and dividend negative
    logic        r_neg2;     // signed mode and divisor negative
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_trial;
    logic [64:0] w_step;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Two's complement negation, wrapping to 32 bits.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Operand magnitudes, one restoring step, and sign correction of the final result.
    always_comb begin
        w_abs1  = bus.opdata1_i;
        w_abs2  = bus.opdata2_i;
        w_trial = 33'd0;
        w_step  = r_work;
        w_quot  = r_work[31:0];
        w_rem   = r_work[64:33];

        if (bus.signed_div_i && bus.opdata1_i[31]) begin
            w_abs1 = neg32(bus.opdata1_i);
        end else begin
            w_abs1 = bus.opdata1_i;
        end

        if (bus.signed_div_i && bus.opdata2_i[31]) begin
            w_abs2 = neg32(bus.opdata2_i);
        end else begin
            w_abs2 = bus.opdata2_i;
        end

        // Partial remainder sits in [63:32] after the pre-shift; a borrow means the trial failed.
        w_trial = {1'b0, r_work[63:32]} - {1'b0, r_divisor};
        if (w_trial[32]) begin
            w_step = {r_work[63:0], 1'b0};
        end else begin
            w_step = {w_trial[31:0], r_work[31:0], 1'b1};
        end

        if (r_neg1 ^ r_neg2) begin
            w_quot = neg32(r_work[31:0]);
        end else begin
            w_quot = r_work[31:0];
        end

        if (r_neg1) begin
            w_rem = neg32(r_work[64:33]);
        end else begin
            w_rem = r_work[64:33];
        end
    end

    // Divider control FSM: accept, iterate, present, and release the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_neg1    <= 1'b0;
            r_neg2    <= 1'b0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else if (bus.annul_i) begin
            // Flush wins over everything; no partial result is ever shown.
            r_state  <= ST_FREE;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_FREE: begin
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                    if (bus.start_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            r_state <= ST_BY_ZERO;
                        end else begin
                            // Pre-shift by one so the first step already sees the dividend MSB.
                            r_work    <= {32'd0, w_abs1, 1'b0};
                            r_divisor <= w_abs2;
                            r_neg1    <= bus.signed_div_i & bus.opdata1_i[31];
                            r_neg2    <= bus.signed_div_i & bus.opdata2_i[31];
                            r_cnt     <= 6'd0;
                            r_state   <= ST_ON;
                        end
                    end else begin
                        r_state <= ST_FREE;
                    end
                end
                ST_BY_ZERO: begin
                    r_work  <= 65'd0;
                    r_neg1  <= 1'b0;
                    r_neg2  <= 1'b0;
                    r_state <= ST_END;
                end
                ST_ON: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= ST_END;
                    end else begin
                        r_state <= ST_ON;
                    end
                end
                ST_END: begin
                    if (!r_ready) begin
                        // First END cycle publishes the result regardless of start_i.
                        r_result <= {w_rem, w_quot};
                        r_ready  <= 1'b1;
                    end else if (bus.start_i) begin
                        r_ready  <= 1'b1;
                    end else begin
                        r_state  <= ST_FREE;
                        r_cnt    <= 6'd0;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_FREE;
                    r_cnt    <= 6'd0;
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
endmodule
